// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and its round-robin front-end arbiter.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  localparam logic [3:0] ALU_OP_LAST = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; illegal opcodes return 0. Shift amounts use the full operand.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  output logic [XLEN-1:0] o_c
);

  always_comb begin
    o_c = '0;
    case (i_op)
      ALU_ADD:  o_c = i_a + i_b;
      ALU_SLL:  o_c = i_a << i_b;
      ALU_SLT:  o_c = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_c = {{(XLEN-1){1'b0}}, i_a < i_b};
      ALU_XOR:  o_c = i_a ^ i_b;
      ALU_SRL:  o_c = i_a >> i_b;
      ALU_SRA:  o_c = $unsigned($signed(i_a) >>> i_b);
      ALU_OR:   o_c = i_a | i_b;
      ALU_AND:  o_c = i_a & i_b;
      ALU_SUB:  o_c = i_a - i_b;
      default:  o_c = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping mod NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_gnt_valid,
  output logic [IW-1:0]   o_gnt_idx
);

  logic [IW:0] w_sum;

  // Scan from the far end so the index closest to i_ptr is the one left standing.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_sum       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      if (i_req[w_sum[IW-1:0]]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = w_sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters with a registered response.
// Optional ALU_ARB_ILLEGAL_OP_EN flags granted opcodes above ALU_OP_LAST on rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NREQ-1:0]            i_req_valid,
  output logic [NREQ-1:0]            o_req_ready,
  input  logic [NREQ-1:0][XLEN-1:0]  i_req_a,
  input  logic [NREQ-1:0][XLEN-1:0]  i_req_b,
  input  logic [NREQ-1:0][3:0]       i_req_op,
  output logic [NREQ-1:0]            o_rsp_valid,
  input  logic [NREQ-1:0]            i_rsp_ready,
  output logic [XLEN-1:0]            o_rsp_c,
  output logic                       o_rsp_err,
  output logic                       o_busy
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e      r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [XLEN-1:0] r_rsp_c;

  logic            w_owner_ready;
  logic            w_can_accept;
  logic            w_gnt_valid;
  logic [IW-1:0]   w_gnt_idx;
  logic [IW-1:0]   w_next_ptr;
  logic            w_accept;
  logic [XLEN-1:0] w_alu_c;

  assign w_owner_ready = i_rsp_ready[r_owner];
  // Reset gates the grant so no requester sees ready while rst_n is low.
  assign w_can_accept  = i_rst_n && ((r_state == IDLE) || ((r_state == RESP) && w_owner_ready));
  assign w_accept      = w_can_accept && w_gnt_valid;
  assign w_next_ptr    = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req       (i_req_valid),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  alu u_alu (
    .i_a  (i_req_a[w_gnt_idx]),
    .i_b  (i_req_b[w_gnt_idx]),
    .i_op (i_req_op[w_gnt_idx]),
    .o_c  (w_alu_c)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_rsp_c <= '0;
    end else if (w_accept) begin
      r_state <= RESP;
      r_owner <= w_gnt_idx;
      r_ptr   <= w_next_ptr;
      r_rsp_c <= w_alu_c;
    end else if ((r_state == RESP) && w_owner_ready) begin
      r_state <= IDLE;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic r_rsp_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_rsp_err <= (i_req_op[w_gnt_idx] > ALU_OP_LAST);
    end
  end

  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    o_rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_rsp_valid[i] = (r_state == RESP) && (r_owner == IW'(i));
    end
  end

  assign o_rsp_c = r_rsp_c;
  assign o_busy  = |o_rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed literal checks plus randomized traffic against a
// transaction-level model; honours ALU_ARB_ILLEGAL_OP_EN when defined.
module tb_alu_arbiter;

  localparam int NREQ = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a = '0;
  logic [NREQ-1:0][31:0] req_b = '0;
  logic [NREQ-1:0][3:0]  req_op = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [31:0]           rsp_c;
  logic                  rsp_err;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one pending result slot, its owner, next scan start, and the result.
  bit          m_busy  = 1'b0;
  int          m_owner = 0;
  int          m_ptr   = 0;
  logic [31:0] m_c     = '0;
  logic        m_err   = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NREQ (NREQ)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_op    (req_op),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_c     (rsp_c),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return (b >= 32) ? 32'd0 : (a << b[4:0]);
      4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3: return (a < b) ? 32'd1 : 32'd0;
      4'd4: return a ^ b;
      4'd5: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
      4'd6: return (b >= 32) ? (a[31] ? 32'hFFFF_FFFF : 32'd0)
                             : $unsigned($signed(a) >>> b[4:0]);
      4'd7: return a | b;
      4'd8: return a & b;
      4'd9: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int grant_idx();
    if (!rst_n) return -1;
    if (m_busy && !rsp_ready[m_owner]) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (grant_idx() >= 0) r[grant_idx()] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_err(input logic [3:0] op);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    return op > 4'd9;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
    end else if (grant_idx() >= 0) begin
      m_busy  <= 1'b1;
      m_owner <= grant_idx();
      m_ptr   <= (grant_idx() + 1) % NREQ;
      m_c     <= alu_ref(req_a[grant_idx()], req_b[grant_idx()], req_op[grant_idx()]);
      m_err   <= exp_err(req_op[grant_idx()]);
    end else if (m_busy && rsp_ready[m_owner]) begin
      m_busy <= 1'b0;
    end
  end

  // Compare process: every falling edge, outputs must match the model.
  always @(negedge clk) begin
    logic [NREQ-1:0] ev;
    ev = '0;
    if (m_busy) ev[m_owner] = 1'b1;
    chk("m_req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("m_busy", 32'(busy), 32'(m_busy));
    if (m_busy) begin
      chk("m_rsp_c", rsp_c, m_c);
      chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] seen;

    // Reset with random inputs.
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = NREQ'($urandom);
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_op = {4'($urandom), 4'($urandom)};
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single request: 5 + 7.
    cyc();
    req_valid = 2'b01; req_a[0] = 5; req_b[0] = 7; req_op[0] = 4'd0; rsp_ready = 2'b11;
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'b01);
    chk("single_rsp_c", rsp_c, 32'd12);
    chk("single_rsp_err", 32'(rsp_err), 32'd0);

    // Contention after a mid-cycle reset pulse.
    cyc();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    req_valid = 2'b11;
    req_a[0] = 32'hF0; req_b[0] = 32'hFF; req_op[0] = 4'd4;
    req_a[1] = 3;      req_b[1] = 5;      req_op[1] = 4'd9;
    @(negedge clk);
    chk("cont_first_ready", 32'(req_ready), 32'b01);
    cyc();
    req_valid = 2'b10;
    @(negedge clk);
    chk("cont_rsp0_c", rsp_c, 32'h0000_000F);
    chk("cont_second_ready", 32'(req_ready), 32'b10);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("cont_rsp1_valid", 32'(rsp_valid), 32'b10);
    chk("cont_rsp1_c", rsp_c, 32'hFFFF_FFFE);

    // Backpressure: 1+1 held by owner while req1 (10-3) waits.
    cyc();
    req_valid = 2'b11;
    req_a[0] = 1;  req_b[0] = 1; req_op[0] = 4'd0;
    req_a[1] = 10; req_b[1] = 3; req_op[1] = 4'd9;
    @(negedge clk);
    chk("bp_ptr_wrap_ready", 32'(req_ready), 32'b01);
    cyc();
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_c", rsp_c, 32'd2);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'b10);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("bp_rsp1_valid", 32'(rsp_valid), 32'b10);
    chk("bp_rsp1_c", rsp_c, 32'd7);

    // Illegal opcode.
    cyc();
    req_valid = 2'b01; req_a[0] = 1; req_b[0] = 1; req_op[0] = 4'd12;
    @(negedge clk);
    chk("ill_ready", 32'(req_ready), 32'b01);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("ill_rsp_c", rsp_c, 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("ill_rsp_err", 32'(rsp_err), 32'd1);
`else
    chk("ill_rsp_err", 32'(rsp_err), 32'd0);
`endif

    // Asynchronous reset while req1 owns a pending response.
    cyc();
    req_valid = 2'b10; req_a[1] = 9; req_b[1] = 4; req_op[1] = 4'd0; rsp_ready = 2'b00;
    @(negedge clk);
    chk("ar_ready", 32'(req_ready), 32'b10);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("ar_rsp_valid_pre", 32'(rsp_valid), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid_async", 32'(rsp_valid), 32'd0);
    chk("ar_busy_async", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("ar_first_grant", 32'(req_ready), 32'b01);

    // Randomized traffic; requesters hold until they see ready.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      seen = req_ready;
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || seen[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[i]     = $urandom;
          req_b[i]     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
          req_op[i]    = 4'($urandom_range(0, 15));
        end
      end
      rsp_ready = NREQ'($urandom);
      if ($urandom_range(0, 3) != 0) rsp_ready = 2'b11;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
